// File: rtl/adc0804_sampler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adc0804_sampler_if
//  Purpose  : Bundles the ADC0804 pins (intr, adc, adc_wr, adc_rd) and the
//             downstream result handshake (temp_bin, temp_bcd, sample_valid,
//             sample_ready, timeout_err).
//  Modports : master - the sampler (drives strobes and results)
//             slave  - ADC + downstream consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface adc0804_sampler_if;
    logic        intr;          // ADC INTR, asynchronous, high = converting
    logic [7:0]  adc;           // ADC data bus
    logic        adc_wr;        // active-low start-conversion strobe
    logic        adc_rd;        // active-low ADC output enable
    logic [8:0]  temp_bin;      // temperature, binary degrees C
    logic [11:0] temp_bcd;      // {hundreds, tens, ones}
    logic        sample_valid;  // result available
    logic        sample_ready;  // downstream accepts result
    logic        timeout_err;   // sticky conversion-timeout flag

    modport master (
        input  intr, adc, sample_ready,
        output adc_wr, adc_rd, temp_bin, temp_bcd, sample_valid, timeout_err
    );

    modport slave (
        output intr, adc, sample_ready,
        input  adc_wr, adc_rd, temp_bin, temp_bcd, sample_valid, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/adc0804_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adc0804_sampler
//  Purpose  : Paces ADC0804 conversions, runs the WR/INTR/RD handshake,
//             scales the 8-bit code to whole degrees C ((code*500)>>8) and
//             converts it to three BCD digits, then offers the result over a
//             valid/ready handshake.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-low reset
//             bus  - adc0804_sampler_if.master (ADC pins + result handshake)
//  Revision : 1.0 - initial release
// ============================================================================
module adc0804_sampler #(
    parameter int SAMPLE_GAP  = 50000,
    parameter int WR_LOW_CYC  = 4,
    parameter int RD_CYC      = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    adc0804_sampler_if.master   bus
);

    localparam int GAP_W = $clog2(SAMPLE_GAP + 1);
    localparam int WR_W  = $clog2(WR_LOW_CYC + 1);
    localparam int RD_W  = $clog2(RD_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_READ      = 3'd4,
        S_CONV      = 3'd5,
        S_BCD       = 3'd6,
        S_HOLD      = 3'd7
    } state_t;

    state_t             state_q,    state_d;
    logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
    logic [WR_W-1:0]    wr_cnt_q,   wr_cnt_d;
    logic [RD_W-1:0]    rd_cnt_q,   rd_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
    logic [3:0]         bit_cnt_q,  bit_cnt_d;
    logic               intr_s1_q,  intr_s1_d;
    logic               intr_s2_q,  intr_s2_d;
    logic [7:0]         code_q,     code_d;
    logic [20:0]        scratch_q,  scratch_d;
    logic               adc_wr_q,   adc_wr_d;
    logic               adc_rd_q,   adc_rd_d;
    logic [8:0]         temp_bin_q, temp_bin_d;
    logic [11:0]        temp_bcd_q, temp_bcd_d;
    logic               valid_q,    valid_d;
    logic               err_q,      err_d;

    logic [16:0]        w_prod;
    logic [20:0]        w_bcd_adj;
    logic [20:0]        w_bcd_shift;
    logic               w_timeout;

    // code * 500 never exceeds 127500, so 17 bits hold it exactly.
    assign w_prod    = {9'd0, code_q} * 17'd500;
    assign w_timeout = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // One double-dabble step: digits >= 5 get +3 before the left shift.
    always_comb begin
        w_bcd_adj = scratch_q;
        if (w_bcd_adj[20:17] >= 4'd5) w_bcd_adj[20:17] = w_bcd_adj[20:17] + 4'd3;
        if (w_bcd_adj[16:13] >= 4'd5) w_bcd_adj[16:13] = w_bcd_adj[16:13] + 4'd3;
        if (w_bcd_adj[12:9]  >= 4'd5) w_bcd_adj[12:9]  = w_bcd_adj[12:9]  + 4'd3;
        w_bcd_shift = {w_bcd_adj[19:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        to_cnt_d   = to_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        intr_s1_d  = bus.intr;
        intr_s2_d  = intr_s1_q;
        code_d     = code_q;
        scratch_d  = scratch_q;
        adc_wr_d   = adc_wr_q;
        adc_rd_d   = adc_rd_q;
        temp_bin_d = temp_bin_q;
        temp_bcd_d = temp_bcd_q;
        valid_d    = valid_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (gap_cnt_q == GAP_W'(SAMPLE_GAP - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = S_START;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            // The counter runs 0..WR_LOW_CYC; the first START cycle pulls WR
            // low, so the low pulse is exactly WR_LOW_CYC cycles.
            S_START: begin
                if (wr_cnt_q == WR_W'(WR_LOW_CYC)) begin
                    adc_wr_d = 1'b1;
                    wr_cnt_d = '0;
                    to_cnt_d = '0;
                    state_d  = S_WAIT_BUSY;
                end else begin
                    adc_wr_d = 1'b0;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            // Timeout wins here so the counter can never run past its limit
            // on the way into WAIT_DONE.
            S_WAIT_BUSY: begin
                if (w_timeout) begin
                    err_d     = 1'b1;
                    to_cnt_d  = '0;
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (intr_s2_q) state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!intr_s2_q) begin
                    to_cnt_d = '0;
                    state_d  = S_READ;
                end else if (w_timeout) begin
                    err_d     = 1'b1;
                    to_cnt_d  = '0;
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            // Data is taken on the edge that releases RD, i.e. while the ADC
            // outputs are still enabled.
            S_READ: begin
                if (rd_cnt_q == RD_W'(RD_CYC)) begin
                    adc_rd_d = 1'b1;
                    rd_cnt_d = '0;
                    code_d   = bus.adc;
                    state_d  = S_CONV;
                end else begin
                    adc_rd_d = 1'b0;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_CONV: begin
                temp_bin_d = w_prod[16:8];
                scratch_d  = {12'd0, w_prod[16:8]};
                bit_cnt_d  = 4'd0;
                state_d    = S_BCD;
            end
            S_BCD: begin
                scratch_d = w_bcd_shift;
                if (bit_cnt_q == 4'd8) begin
                    temp_bcd_d = w_bcd_shift[20:9];
                    valid_d    = 1'b1;
                    state_d    = S_HOLD;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (valid_q && bus.sample_ready) begin
                    valid_d   = 1'b0;
                    err_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            to_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            intr_s1_q  <= 1'b0;
            intr_s2_q  <= 1'b0;
            code_q     <= '0;
            scratch_q  <= '0;
            adc_wr_q   <= 1'b1;
            adc_rd_q   <= 1'b1;
            temp_bin_q <= '0;
            temp_bcd_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            to_cnt_q   <= to_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            intr_s1_q  <= intr_s1_d;
            intr_s2_q  <= intr_s2_d;
            code_q     <= code_d;
            scratch_q  <= scratch_d;
            adc_wr_q   <= adc_wr_d;
            adc_rd_q   <= adc_rd_d;
            temp_bin_q <= temp_bin_d;
            temp_bcd_q <= temp_bcd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.adc_wr       = adc_wr_q;
    assign bus.adc_rd       = adc_rd_q;
    assign bus.temp_bin     = temp_bin_q;
    assign bus.temp_bcd     = temp_bcd_q;
    assign bus.sample_valid = valid_q;
    assign bus.timeout_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc0804_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adc0804_sampler
//  Purpose  : Directed self-checking bench for adc0804_sampler with short
//             pacing parameters. Drives the ADC INTR/data pins and the
//             downstream ready line, and checks strobes, timing and results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc0804_sampler;

    localparam int SAMPLE_GAP  = 20;
    localparam int WR_LOW_CYC  = 4;
    localparam int RD_CYC      = 4;
    localparam int TIMEOUT_CYC = 500;
    localparam int WAIT_LIMIT  = 4 * SAMPLE_GAP + TIMEOUT_CYC + 100;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    adc0804_sampler_if bus ();

    adc0804_sampler #(
        .SAMPLE_GAP  (SAMPLE_GAP),
        .WR_LOW_CYC  (WR_LOW_CYC),
        .RD_CYC      (RD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until adc_wr is seen low; n = ticks taken.
    task automatic wait_wr_fall(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < WAIT_LIMIT) begin
            tick();
            n++;
            if (bus.adc_wr === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Entered right after adc_wr is seen low. Plays the ADC: intr rises two
    // cycles after the WR fall and drops `busy` cycles later. Returns when
    // sample_valid is seen high.
    task automatic drive_conv(input logic [7:0] code, input int busy,
                              output int wr_len, output int rd_len,
                              output int rd_to_valid, output bit ok);
        int t       = 0;
        int t_wr_hi = -1;
        int t_rd_lo = -1;
        int t_rd_hi = -1;
        bus.adc = code;
        ok = 1'b0;
        while (t < busy + 200) begin
            tick();
            t++;
            if (t == 2)        bus.intr = 1'b1;
            if (t == 2 + busy) bus.intr = 1'b0;
            if (t_wr_hi < 0 && bus.adc_wr === 1'b1) t_wr_hi = t;
            if (t_rd_lo < 0 && bus.adc_rd === 1'b0) t_rd_lo = t;
            if (t_rd_lo >= 0 && t_rd_hi < 0 && bus.adc_rd === 1'b1) t_rd_hi = t;
            if (bus.sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.intr    = 1'b0;
        wr_len      = t_wr_hi;
        rd_len      = (t_rd_lo >= 0 && t_rd_hi >= 0) ? t_rd_hi - t_rd_lo : -1;
        rd_to_valid = (t_rd_hi >= 0) ? t - t_rd_hi : -1;
    endtask

    function automatic int exp_bin(input int code);
        return (code * 500) / 256;
    endfunction

    function automatic int exp_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic test_reset();
        int n;
        bit ok;
        bus.intr = 1'b0;
        bus.adc = 8'h00;
        bus.sample_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.adc_wr !== 1'b1) begin n_fail++; $display("FAIL reset_wr: got %b want 1", bus.adc_wr); end
        n_tests++; if (bus.adc_rd !== 1'b1) begin n_fail++; $display("FAIL reset_rd: got %b want 1", bus.adc_rd); end
        n_tests++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.sample_valid); end
        n_tests++; if (bus.temp_bin !== 9'd0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", bus.temp_bin); end
        n_tests++; if (bus.temp_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h want 000", bus.temp_bcd); end
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.timeout_err); end
        rst = 1'b1;
        wait_wr_fall(n, ok);
        n_tests++;
        if (!ok || n != SAMPLE_GAP + 1) begin
            n_fail++; $display("FAIL reset_first_wr: got %0d cycles (seen=%0d) want %0d", n, ok, SAMPLE_GAP + 1);
        end
    endtask

    task automatic test_nominal();
        int wl, rl, rv, n;
        bit ok, ok2;
        bus.sample_ready = 1'b1;
        drive_conv(8'h95, 350, wl, rl, rv, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL nom_valid: got 0 want 1"); end
        n_tests++; if (wl != WR_LOW_CYC) begin n_fail++; $display("FAIL nom_wr_len: got %0d want %0d", wl, WR_LOW_CYC); end
        n_tests++; if (rl != RD_CYC) begin n_fail++; $display("FAIL nom_rd_len: got %0d want %0d", rl, RD_CYC); end
        n_tests++; if (rv != 10) begin n_fail++; $display("FAIL nom_rd_to_valid: got %0d want 10", rv); end
        n_tests++; if (bus.temp_bin !== 9'd291) begin n_fail++; $display("FAIL nom_bin: got %0d want 291", bus.temp_bin); end
        n_tests++; if (bus.temp_bcd !== 12'h291) begin n_fail++; $display("FAIL nom_bcd: got %h want 291", bus.temp_bcd); end
        tick();
        n_tests++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL nom_valid_pulse: got %b want 0", bus.sample_valid); end
        wait_wr_fall(n, ok2);
        n_tests++;
        if (!ok2 || n != SAMPLE_GAP + 1) begin
            n_fail++; $display("FAIL nom_next_wr: got %0d want %0d", n + 1, SAMPLE_GAP + 2);
        end
    endtask

    task automatic test_sweep();
        int wl, rl, rv, n, eb;
        bit ok, ok2;
        bus.sample_ready = 1'b1;
        for (int code = 0; code < 256; code++) begin
            drive_conv(code[7:0], 5, wl, rl, rv, ok);
            eb = exp_bin(code);
            n_tests++;
            if (!ok || bus.temp_bin !== eb[8:0]) begin
                n_fail++; $display("FAIL sweep_bin code=%h: got %0d want %0d", code[7:0], bus.temp_bin, eb);
            end
            n_tests++;
            if (!ok || bus.temp_bcd !== 12'(exp_bcd(eb))) begin
                n_fail++; $display("FAIL sweep_bcd code=%h: got %h want %h", code[7:0], bus.temp_bcd, 12'(exp_bcd(eb)));
            end
            tick();
            wait_wr_fall(n, ok2);
            if (!ok2) begin
                n_tests++; n_fail++; $display("FAIL sweep_wr_wait code=%h: got no WR want WR", code[7:0]);
                break;
            end
        end
    endtask

    task automatic test_backpressure();
        int wl, rl, rv, n;
        bit ok, ok2;
        bit v_stable = 1'b1, d_stable = 1'b1, wr_quiet = 1'b1;
        bus.sample_ready = 1'b0;
        drive_conv(8'h33, 5, wl, rl, rv, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_valid: got 0 want 1"); end
        n_tests++; if (bus.temp_bin !== 9'd99) begin n_fail++; $display("FAIL bp_bin: got %0d want 99", bus.temp_bin); end
        n_tests++; if (bus.temp_bcd !== 12'h099) begin n_fail++; $display("FAIL bp_bcd: got %h want 099", bus.temp_bcd); end
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.sample_valid !== 1'b1) v_stable = 1'b0;
            if (bus.temp_bin !== 9'd99 || bus.temp_bcd !== 12'h099) d_stable = 1'b0;
            if (bus.adc_wr !== 1'b1) wr_quiet = 1'b0;
        end
        n_tests++; if (!v_stable) begin n_fail++; $display("FAIL bp_valid_hold: got drop want steady 1"); end
        n_tests++; if (!d_stable) begin n_fail++; $display("FAIL bp_data_hold: got change want 99/099"); end
        n_tests++; if (!wr_quiet) begin n_fail++; $display("FAIL bp_wr_quiet: got WR activity want none"); end
        bus.sample_ready = 1'b1;
        tick();
        n_tests++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall: got %b want 0", bus.sample_valid); end
        wait_wr_fall(n, ok2);
        n_tests++;
        if (!ok2 || n != SAMPLE_GAP + 1) begin
            n_fail++; $display("FAIL bp_next_wr: got %0d want %0d", n, SAMPLE_GAP + 1);
        end
    endtask

    // stuck_high=0: intr never rises (WAIT_BUSY). stuck_high=1: intr rises and
    // never falls (WAIT_DONE). Then a good conversion must clear the flag.
    task automatic test_timeout(input bit stuck_high, input logic [7:0] code, input int want_bin);
        int t = 0, cnt = 0, n, wl, rl, rv;
        bit saw_valid = 1'b0, ok, ok2;
        bus.sample_ready = 1'b1;
        bus.intr = 1'b0;
        while (bus.adc_wr !== 1'b1 && t < 50) begin
            tick();
            t++;
            if (stuck_high && t == 2) bus.intr = 1'b1;
        end
        while (bus.timeout_err !== 1'b1 && cnt < TIMEOUT_CYC + 50) begin
            tick();
            cnt++;
            if (bus.sample_valid === 1'b1) saw_valid = 1'b1;
        end
        n_tests++;
        if (cnt != TIMEOUT_CYC) begin
            n_fail++; $display("FAIL to%0d_latency: got %0d want %0d", stuck_high, cnt, TIMEOUT_CYC);
        end
        n_tests++; if (saw_valid) begin n_fail++; $display("FAIL to%0d_no_valid: got valid want none", stuck_high); end
        bus.intr = 1'b0;
        wait_wr_fall(n, ok);
        n_tests++;
        if (!ok || n != SAMPLE_GAP + 1) begin
            n_fail++; $display("FAIL to%0d_retry: got %0d want %0d", stuck_high, n, SAMPLE_GAP + 1);
        end
        drive_conv(code, 5, wl, rl, rv, ok2);
        n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to%0d_sticky: got %b want 1", stuck_high, bus.timeout_err); end
        n_tests++;
        if (!ok2 || bus.temp_bin !== want_bin[8:0]) begin
            n_fail++; $display("FAIL to%0d_bin: got %0d want %0d", stuck_high, bus.temp_bin, want_bin);
        end
        n_tests++;
        if (bus.temp_bcd !== 12'(exp_bcd(want_bin))) begin
            n_fail++; $display("FAIL to%0d_bcd: got %h want %h", stuck_high, bus.temp_bcd, 12'(exp_bcd(want_bin)));
        end
        tick();
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to%0d_clear: got %b want 0", stuck_high, bus.timeout_err); end
        wait_wr_fall(n, ok);
        if (!ok) begin n_tests++; n_fail++; $display("FAIL to%0d_wr_wait: got no WR want WR", stuck_high); end
    endtask

    task automatic test_reset_wait_done();
        int n;
        bit ok;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 2) bus.intr = 1'b1;
        end
        n_tests++; if (bus.temp_bin !== 9'd292) begin n_fail++; $display("FAIL rwd_pre_bin: got %0d want 292", bus.temp_bin); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus.adc_wr !== 1'b1) begin n_fail++; $display("FAIL rwd_wr: got %b want 1", bus.adc_wr); end
        n_tests++; if (bus.adc_rd !== 1'b1) begin n_fail++; $display("FAIL rwd_rd: got %b want 1", bus.adc_rd); end
        n_tests++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL rwd_valid: got %b want 0", bus.sample_valid); end
        n_tests++; if (bus.temp_bin !== 9'd0) begin n_fail++; $display("FAIL rwd_bin: got %0d want 0", bus.temp_bin); end
        n_tests++; if (bus.temp_bcd !== 12'h000) begin n_fail++; $display("FAIL rwd_bcd: got %h want 000", bus.temp_bcd); end
        bus.intr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        wait_wr_fall(n, ok);
        n_tests++;
        if (!ok || n != SAMPLE_GAP + 1) begin
            n_fail++; $display("FAIL rwd_restart: got %0d want %0d", n, SAMPLE_GAP + 1);
        end
    endtask

    task automatic test_reset_bcd();
        int t = 0, n, wl, rl, rv;
        bit ok, ok2, rd_lo = 1'b0, rd_done = 1'b0;
        bus.adc = 8'hFF;
        bus.sample_ready = 1'b1;
        while (!rd_done && t < 100) begin
            tick();
            t++;
            if (t == 2) bus.intr = 1'b1;
            if (t == 7) bus.intr = 1'b0;
            if (bus.adc_rd === 1'b0) rd_lo = 1'b1;
            if (rd_lo && bus.adc_rd === 1'b1) rd_done = 1'b1;
        end
        bus.intr = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.temp_bin !== 9'd498) begin n_fail++; $display("FAIL rbcd_pre_bin: got %0d want 498", bus.temp_bin); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus.adc_wr !== 1'b1 || bus.adc_rd !== 1'b1) begin n_fail++; $display("FAIL rbcd_strobes: got wr=%b rd=%b want 1/1", bus.adc_wr, bus.adc_rd); end
        n_tests++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL rbcd_valid: got %b want 0", bus.sample_valid); end
        n_tests++; if (bus.temp_bin !== 9'd0) begin n_fail++; $display("FAIL rbcd_bin: got %0d want 0", bus.temp_bin); end
        n_tests++; if (bus.temp_bcd !== 12'h000) begin n_fail++; $display("FAIL rbcd_bcd: got %h want 000", bus.temp_bcd); end
        tick();
        tick();
        rst = 1'b1;
        wait_wr_fall(n, ok);
        n_tests++;
        if (!ok || n != SAMPLE_GAP + 1) begin
            n_fail++; $display("FAIL rbcd_restart: got %0d want %0d", n, SAMPLE_GAP + 1);
        end
        drive_conv(8'h95, 5, wl, rl, rv, ok2);
        n_tests++;
        if (!ok2 || bus.temp_bin !== 9'd291 || bus.temp_bcd !== 12'h291) begin
            n_fail++; $display("FAIL rbcd_after: got %0d/%h want 291/291", bus.temp_bin, bus.temp_bcd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sweep();
        test_backpressure();
        test_timeout(1'b0, 8'hFF, 498);
        test_timeout(1'b1, 8'h96, 292);
        test_reset_wait_done();
        test_reset_bcd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/adc0804_sampler.md
# adc0804_sampler

Upstream acquisition stage for the LM35 temperature display path. It paces ADC0804 conversions, runs the WR/INTR/RD handshake, and latches the 8-bit code. It scales the code to whole degrees Celsius (5 V reference, 10 mV/°C) and converts the result to three BCD digits. Each result is handed to the LCD formatting stage over a valid/ready handshake.

## Interface
- SAMPLE_GAP, 50000: idle cycles between a completed handoff (or a timeout) and the next conversion start.
- WR_LOW_CYC, 4: width of the adc_wr low pulse, in cycles (≥1).
- RD_CYC, 4: width of the adc_rd low pulse, in cycles (≥1).
- TIMEOUT_CYC, 100000: maximum cycles from the end of the WR pulse to the synced INTR falling edge.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- intr  in  1  ADC0804 INTR: high = converting, low = done. Asynchronous; double-flopped internally.
- adc  in  8  ADC0804 data bus; sampled only during READ.
- adc_wr  out  1  active-low start-conversion strobe.
- adc_rd  out  1  active-low output enable to the ADC.
- temp_bin  out  9  temperature, binary °C (0..498).
- temp_bcd  out  12  {hundreds, tens, ones} BCD of temp_bin.
- sample_valid  out  1  result available.
- sample_ready  in  1  downstream accepts the result.
- timeout_err  out  1  sticky; set on timeout, cleared by the next successful handoff.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, READ, CONV, BCD, HOLD.
- IDLE: gap counter runs up to SAMPLE_GAP−1, then the block enters START.
- START: adc_wr=0 for WR_LOW_CYC cycles, then adc_wr=1 and the block enters WAIT_BUSY.
- WAIT_BUSY: waits for synced intr=1.
- WAIT_DONE: waits for synced intr=0.
  - The timeout counter spans WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYC, the block sets timeout_err, returns to IDLE and restarts the gap counter. Outputs are unchanged and no valid is raised.
- READ: adc_rd=0 for RD_CYC cycles. adc is captured on the last READ cycle.
- CONV: temp_bin ← (code × 500) >> 8, using a 17-bit product and truncation. No rounding.
- BCD: 9-iteration shift-and-add-3, one bit per cycle, over a 21-bit scratch register. temp_bcd updates only when the conversion finishes.
- HOLD: sample_valid=1. temp_bin and temp_bcd are stable while valid is high.
  - A cycle with sample_valid & sample_ready is the handoff. On handoff: valid drops next cycle, timeout_err clears, the gap counter restarts, and the block enters IDLE.
- Backpressure: no new conversion starts while HOLD is pending. adc_wr stays high indefinitely if ready never asserts.
- temp_bin and temp_bcd hold the last good result through later conversions until they are overwritten at the end of CONV and BCD respectively.

## Timing
- Reset values, applied asynchronously: adc_wr=1, adc_rd=1, sample_valid=0, temp_bin=0, temp_bcd=0, timeout_err=0, state=IDLE, all counters 0, sync flops 0.
- Reset asserted mid-operation: WR and RD release high immediately. After release, the first adc_wr fall occurs SAMPLE_GAP+1 cycles after the first rising clk edge with rst=1.
- adc_wr falls on the first cycle in START. The WR pulse is exactly WR_LOW_CYC cycles.
- intr sync latency is 2 cycles. A low-going intr pulse shorter than 1 cycle may be missed; the timeout covers this case.
- adc_rd falls on the cycle after WAIT_DONE sees synced intr=0. The RD pulse is exactly RD_CYC cycles.
- sample_valid rises 10 cycles after adc_rd returns high: 1 CONV cycle + 9 BCD cycles.
- sample_ready asserted before valid has no effect. Ready held high gives a single-cycle valid pulse.
- Timeout and handoff cannot coincide; they occur in disjoint states.
- Arithmetic corner values: code 0 → 0 / 0x000; 0x33 → 99 / 0x099; 0x95 → 291 / 0x291; 0x96 → 292 / 0x292; 0xFF → 498 / 0x498.

## Test plan
- Reset/idle: hold rst=0, then release. Required: every output at its reset value, and adc_wr falls exactly SAMPLE_GAP+1 cycles after release.
- Nominal conversion, ADC model with adc=0x95: raise intr 2 cycles after the adc_wr fall, drop it 350 cycles later, ready=1. Required: WR low for 4 cycles, RD low for 4 cycles, then valid for one cycle with temp_bin=291 and temp_bcd=0x291. The next WR follows SAMPLE_GAP+1 cycles after the handoff.
- Code sweep 0x00..0xFF, checked against a reference model of (code×500)>>8 and its BCD. Includes 0x33→0x099 and 0xFF→0x498.
- Backpressure: ready=0 for 1000 cycles after valid rises. Required: valid and data stable throughout, no adc_wr activity. Raising ready gives a handoff and valid falls on the next cycle.
- Timeout: intr stuck low (WAIT_BUSY) and, separately, intr stuck high (WAIT_DONE). Required: timeout_err=1 TIMEOUT_CYC cycles after the WR pulse ends, no valid, a retry after SAMPLE_GAP. The next good handoff clears timeout_err.
- Reset asserted during WAIT_DONE and during BCD. Required: adc_wr and adc_rd high, valid=0 and temp outputs 0 immediately, and a clean restart after release.
